mixer_seq: RTL and testbench
============================

Name: mixer_seq

Overview:
- Parametrised, time-multiplexed N-channel mixer. Successor to the fixed 4-input combinational mixer.
- Adds per-channel 8-bit gain, a per-channel mute mask, a master attenuation shift, and saturation instead of wrap-around.
- Runs on the system clock and snapshots all voice outputs on each sample_clock rising edge.
- Accumulates one channel per cycle and presents a held mix word to the dac.

Parameters:
NCHAN, 8, number of input channels (2..64)
BITDEPTH, 14, sample width; unsigned offset-binary, center = 2^(BITDEPTH-1)
SHIFT, 2, master attenuation: right shift applied after gain scaling

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sample_clock  input  1  level from sample_clock block; its rising edge starts a frame
in  input  NCHAN*BITDEPTH  packed channel samples; channel k at [k*BITDEPTH +: BITDEPTH]
gain  input  NCHAN*8  packed unsigned gains; channel k at [k*8 +: 8]; effective gain = value/256
mute  input  NCHAN  1 = channel k contributes zero
mix  output  BITDEPTH  mixed sample, registered, held between frames
mix_valid  output  1  one-cycle pulse when mix updates
busy  output  1  high while a frame is in progress
overrun  output  1  one-cycle pulse when a frame start is dropped

Behaviour:
- Edge detect: sc_prev register samples sample_clock every clk. A start occurs when sample_clock=1 and sc_prev=0.
- sc_prev resets to 1, so a high sample_clock at reset release does not start a frame.
- Reset values (async, immediate): mix = 2^(BITDEPTH-1); mix_valid = 0; busy = 0; overrun = 0; state = IDLE; accumulator = 0; idx = 0.
- FSM states: IDLE, ACC, OUT.
  - IDLE: on a start, copy in, gain and mute into snapshot registers, clear the accumulator, set idx = 0, busy = 1, and go to ACC.
  - ACC: each cycle, acc += term(idx).
    - term = 0 if mute[idx]; otherwise (in[idx] - center) as a signed (BITDEPTH+1)-bit value, multiplied by zero-extended gain[idx].
    - If idx == NCHAN-1, go to OUT; otherwise idx++.
  - OUT: r = (acc >>> (8+SHIFT)) + center, using an arithmetic shift (floor).
    - Saturate r to [0, 2^BITDEPTH-1], then register it into mix.
    - Pulse mix_valid = 1, set busy = 0, go to IDLE.
- Accumulator width: BITDEPTH+9+clog2(NCHAN) signed. No intermediate overflow is possible.
- Latency: start detected at clk edge E0. ACC occupies E1..E_NCHAN. mix and mix_valid change at E_NCHAN+1, i.e. NCHAN+1 clks after E0.
- Inputs are sampled only at E0. Changes to in, gain or mute during a frame do not affect that frame.
- Start while busy (state ACC or OUT): the start is ignored and overrun pulses for one cycle. The current frame completes normally, and mix_valid pulses exactly once.
  - Required sample period is > NCHAN+2 clks. The default divider of 256 clks allows NCHAN up to 64.
- Start detected in the same cycle as OUT: treated as overrun, not queued.
- Reset mid-frame: the frame is abandoned, mix returns to center, and no mix_valid pulse occurs.
- mix changes only in OUT or on reset.
- All gains 0 or all channels muted: mix = center exactly.
- Gain 255 is the unity approximation (255/256). Floor rounding biases results toward negative by at most 1 LSB.

Test Plan:
- Defaults (NCHAN=8, BITDEPTH=14, SHIFT=2). Reset, then release -> mix=8192, mix_valid=0, busy=0. No frame starts even if sample_clock is high at release.
- All in=8192, gain=255, one sample_clock rise -> busy high for 9 clks. mix_valid pulses 9 clks after the start edge. mix=8192.
- SHIFT=0: ch0 in=16383, gain0=255, other channels center with gain 0 -> mix = 8192 + floor(8191*255/256) = 16351. With mute[0]=1 -> mix=8192.
- SHIFT=0 saturation:
  - ch0 = ch1 = 16383, gain 255 -> 8192 + 16318 = 24510, clipped to 16383.
  - ch0 = ch1 = 0, gain 255 -> 8192 - 16320 < 0, clipped to 0.
- Overrun: second sample_clock rise 3 clks after the first -> overrun pulses 1 clk, exactly one mix_valid, and mix reflects the first snapshot. Changing in during ACC does not alter the result.
- Reset during ACC (idx=4) after mix previously held 16351 -> mix=8192 and busy=0 immediately. No mix_valid. The next start produces a normal frame.

Source files
------------

// File: rtl/mixer_seq.sv
// Time-multiplexed N-channel mixer: snapshots all channels on a sample_clock rise,
// accumulates one gain-scaled channel per clk, then attenuates, saturates and holds the result.
module mixer_seq #(
   parameter int NCHAN    = 8,
   parameter int BITDEPTH = 14,
   parameter int SHIFT    = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sample_clock,
   input  logic [NCHAN*BITDEPTH-1:0]   in,
   input  logic [NCHAN*8-1:0]          gain,
   input  logic [NCHAN-1:0]            mute,
   output logic [BITDEPTH-1:0]         mix,
   output logic                        mix_valid,
   output logic                        busy,
   output logic                        overrun
);

   localparam int IDXW = $clog2(NCHAN);
   localparam int ACCW = BITDEPTH + 9 + IDXW;
   localparam int PW   = BITDEPTH + 10;

   localparam logic [BITDEPTH-1:0]    CENTER     = {1'b1, {(BITDEPTH-1){1'b0}}};
   localparam logic signed [ACCW-1:0] CENTER_ACC = {{(ACCW-BITDEPTH){1'b0}}, CENTER};
   localparam logic signed [ACCW-1:0] MAX_ACC    = {{(ACCW-BITDEPTH){1'b0}}, {BITDEPTH{1'b1}}};
   localparam logic [IDXW-1:0]        IDX_LAST   = IDXW'(NCHAN - 1);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t                      state_q, state_d;
   logic                        sc_prev_q;
   logic                        start;
   logic signed [ACCW-1:0]      acc_q, acc_d;
   logic [IDXW-1:0]             idx_q, idx_d;
   logic [NCHAN*BITDEPTH-1:0]   in_snap_q, in_snap_d;
   logic [NCHAN*8-1:0]          gain_snap_q, gain_snap_d;
   logic [NCHAN-1:0]            mute_snap_q, mute_snap_d;
   logic [BITDEPTH-1:0]         mix_q, mix_d;
   logic                        mix_valid_q, mix_valid_d;
   logic                        busy_q, busy_d;
   logic                        overrun_q, overrun_d;

   logic [BITDEPTH-1:0]         sel_in;
   logic [7:0]                  sel_gain;
   logic                        sel_mute;
   logic signed [BITDEPTH:0]    diff;
   logic signed [PW-1:0]        prod;
   logic signed [ACCW-1:0]      term;
   logic signed [ACCW-1:0]      shifted;
   logic signed [ACCW-1:0]      r;
   logic [BITDEPTH-1:0]         sat;

   // sc_prev resets high so a sample_clock already high at reset release is not an edge
   assign start = sample_clock & ~sc_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = ACC;
         ACC:     if (idx_q == IDX_LAST) state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_in   = '0;
      sel_gain = '0;
      sel_mute = 1'b0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
         if (32'(idx_q) == k) begin
            sel_in   = in_snap_q[k*BITDEPTH +: BITDEPTH];
            sel_gain = gain_snap_q[k*8 +: 8];
            sel_mute = mute_snap_q[k];
         end
      end
      diff = $signed({1'b0, sel_in}) - $signed({1'b0, CENTER});
      prod = PW'(diff) * PW'($signed({1'b0, sel_gain}));
      term = sel_mute ? '0 : ACCW'(prod);
   end

   // Floor attenuation back to offset binary, then clip to the full unsigned range
   always_comb begin
      shifted = acc_q >>> (8 + SHIFT);
      r       = shifted + CENTER_ACC;
      if (r[ACCW-1]) begin
         sat = '0;
      end else if (r > MAX_ACC) begin
         sat = '1;
      end else begin
         sat = r[BITDEPTH-1:0];
      end
   end

   always_comb begin
      acc_d       = acc_q;
      idx_d       = idx_q;
      in_snap_d   = in_snap_q;
      gain_snap_d = gain_snap_q;
      mute_snap_d = mute_snap_q;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;
      busy_d      = busy_q;
      overrun_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               in_snap_d   = in;
               gain_snap_d = gain;
               mute_snap_d = mute;
               acc_d       = '0;
               idx_d       = '0;
               busy_d      = 1'b1;
            end
         end
         ACC: begin
            acc_d = acc_q + term;
            if (idx_q != IDX_LAST) idx_d = idx_q + 1'b1;
         end
         OUT: begin
            mix_d       = sat;
            mix_valid_d = 1'b1;
            busy_d      = 1'b0;
         end
         default: ;
      endcase
      // A start seen in ACC or OUT is dropped, never queued
      if (start && (state_q != IDLE)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sc_prev_q   <= 1'b1;
         acc_q       <= '0;
         idx_q       <= '0;
         in_snap_q   <= '0;
         gain_snap_q <= '0;
         mute_snap_q <= '0;
         mix_q       <= CENTER;
         mix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sc_prev_q   <= sample_clock;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         in_snap_q   <= in_snap_d;
         gain_snap_q <= gain_snap_d;
         mute_snap_q <= mute_snap_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign mix       = mix_q;
   assign mix_valid = mix_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_mixer_seq.sv
// Bench for mixer_seq: default instance (SHIFT=2) and a SHIFT=0 instance driven in parallel
// from a table of hand-computed vectors, plus overrun and reset-abort sequences.
module tb_mixer_seq;

   localparam int N   = 8;
   localparam int B   = 14;
   localparam int CEN = 8192;

   typedef struct {
      logic [N*B-1:0] in;
      logic [N*8-1:0] gain;
      logic [N-1:0]   mute;
      int             exp2;
      int             exp0;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           sample_clock;
   logic [N*B-1:0] in;
   logic [N*8-1:0] gain;
   logic [N-1:0]   mute;
   logic [B-1:0]   mix2, mix0;
   logic           mv2, mv0, busy2, busy0, ovr2, ovr0;

   int errors = 0;
   int checks = 0;
   vec_t vecs[12];

   mixer_seq dut2 (
      .clk(clk), .rst(rst), .sample_clock(sample_clock), .in(in), .gain(gain), .mute(mute),
      .mix(mix2), .mix_valid(mv2), .busy(busy2), .overrun(ovr2)
   );

   mixer_seq #(.NCHAN(N), .BITDEPTH(B), .SHIFT(0)) dut0 (
      .clk(clk), .rst(rst), .sample_clock(sample_clock), .in(in), .gain(gain), .mute(mute),
      .mix(mix0), .mix_valid(mv0), .busy(busy0), .overrun(ovr0)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t fill(input int s, input int g, input logic m);
      vec_t v;
      for (int k = 0; k < N; k++) begin
         v.in[k*B +: B]    = B'(s);
         v.gain[k*8 +: 8]  = 8'(g);
         v.mute[k]         = m;
      end
      v.exp2 = CEN;
      v.exp0 = CEN;
      return v;
   endfunction

   function automatic vec_t ch(input vec_t v0, input int k, input int s, input int g, input logic m);
      vec_t v = v0;
      v.in[k*B +: B]   = B'(s);
      v.gain[k*8 +: 8] = 8'(g);
      v.mute[k]        = m;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t v0, input int e2, input int e0);
      vec_t v = v0;
      v.exp2 = e2;
      v.exp0 = e0;
      return v;
   endfunction

   task automatic run_frame(input vec_t v, input string tag);
      int  k;
      int  busy_n;
      bit  seen;
      in   = v.in;
      gain = v.gain;
      mute = v.mute;
      sample_clock = 1'b1;
      tick;
      sample_clock = 1'b0;
      k      = 0;
      busy_n = busy2 ? 1 : 0;
      seen   = 1'b0;
      while (!seen && k < 20) begin
         tick;
         k++;
         if (busy2) busy_n++;
         if (mv2) seen = 1'b1;
      end
      check({tag, " latency"}, k, N + 1);
      check({tag, " busy_clks"}, busy_n, N + 1);
      check({tag, " mix_shift2"}, mix2, v.exp2);
      check({tag, " mix_shift0"}, mix0, v.exp0);
      check({tag, " valid_shift0"}, mv0, 1);
      tick;
      check({tag, " valid_pulse"}, mv2, 0);
   endtask

   initial begin
      int   ovr_n, ovr_at, mv_n, busy_late;
      logic [B-1:0] m2, m0;
      vec_t base0, v1;

      rst = 1'b1;
      sample_clock = 1'b1;
      in   = '0;
      gain = '0;
      mute = '0;

      base0 = fill(CEN, 0, 1'b0);
      vecs[0]  = ex(fill(CEN, 255, 1'b0), 8192, 8192);
      vecs[1]  = ex(ch(base0, 0, 16383, 255, 1'b0), 10231, 16351);
      vecs[2]  = ex(ch(base0, 0, 16383, 255, 1'b1), 8192, 8192);
      vecs[3]  = ex(ch(ch(base0, 0, 16383, 255, 1'b0), 1, 16383, 255, 1'b0), 12271, 16383);
      vecs[4]  = ex(ch(ch(base0, 0, 0, 255, 1'b0), 1, 0, 255, 1'b0), 4112, 0);
      vecs[5]  = ex(ch(base0, 0, 8191, 1, 1'b0), 8191, 8191);
      vecs[6]  = ex(ch(base0, 0, 8193, 255, 1'b0), 8192, 8192);
      vecs[7]  = ex(ch(fill(0, 0, 1'b0), 3, 16383, 0, 1'b0), 8192, 8192);
      vecs[8]  = ex(fill(16383, 255, 1'b1), 8192, 8192);
      vecs[9]  = ex(ch(ch(ch(fill(CEN, 200, 1'b0), 2, 9192, 128, 1'b0), 5, 6192, 32, 1'b0),
                       7, 16383, 255, 1'b1), 8254, 8442);
      vecs[10] = ex(ch(base0, 7, 0, 100, 1'b0), 7392, 4992);
      vecs[11] = ex(ch(ch(base0, 3, 12192, 255, 1'b0), 6, 4192, 254, 1'b0), 8195, 8207);
      v1 = vecs[1];

      repeat (3) tick;
      rst = 1'b0;
      // sample_clock is still high here: no frame may start
      for (int c = 0; c < 4; c++) begin
         tick;
         check($sformatf("reset c%0d mix", c), mix2, CEN);
         check($sformatf("reset c%0d busy", c), busy2, 0);
         check($sformatf("reset c%0d valid", c), mv2, 0);
      end
      sample_clock = 1'b0;
      tick;

      for (int i = 0; i < 12; i++) begin
         run_frame(vecs[i], $sformatf("vec%0d", i));
         tick;
      end

      // Second rise 3 clks after the first, inputs changed mid-frame
      in   = v1.in;
      gain = v1.gain;
      mute = v1.mute;
      sample_clock = 1'b1;
      tick;
      in   = '0;
      gain = '1;
      ovr_n = 0; ovr_at = -1; mv_n = 0; m2 = '0; m0 = '0;
      for (int j = 1; j <= 20; j++) begin
         sample_clock = (j == 3);
         tick;
         if (ovr2) begin ovr_n++; ovr_at = j; end
         if (mv2) begin mv_n++; m2 = mix2; m0 = mix0; end
      end
      check("ovr count", ovr_n, 1);
      check("ovr cycle", ovr_at, 3);
      check("ovr valid count", mv_n, 1);
      check("ovr mix_shift2", m2, 10231);
      check("ovr mix_shift0", m0, 16351);

      // Start coinciding with OUT is dropped, not queued
      in   = vecs[5].in;
      gain = vecs[5].gain;
      mute = vecs[5].mute;
      sample_clock = 1'b1;
      tick;
      ovr_n = 0; ovr_at = -1; mv_n = 0; busy_late = 0;
      for (int j = 1; j <= 20; j++) begin
         sample_clock = (j == 9);
         tick;
         if (ovr0) begin ovr_n++; ovr_at = j; end
         if (mv0) mv_n++;
         if (j > 9 && busy0) busy_late++;
      end
      sample_clock = 1'b0;
      check("outstart ovr count", ovr_n, 1);
      check("outstart ovr cycle", ovr_at, 9);
      check("outstart valid count", mv_n, 1);
      check("outstart busy after", busy_late, 0);
      check("outstart mix", mix0, 8191);
      tick;

      // Reset while idx=4 abandons the frame
      run_frame(v1, "prereset");
      tick;
      in   = vecs[10].in;
      gain = vecs[10].gain;
      mute = vecs[10].mute;
      sample_clock = 1'b1;
      tick;
      sample_clock = 1'b0;
      repeat (4) tick;
      check("abort held mix", mix0, 16351);
      check("abort busy before", busy0, 1);
      rst = 1'b1;
      #1;
      check("abort mix_shift0", mix0, CEN);
      check("abort mix_shift2", mix2, CEN);
      check("abort busy", busy0, 0);
      tick;
      rst = 1'b0;
      mv_n = 0;
      for (int j = 0; j < 15; j++) begin
         tick;
         if (mv0 || mv2) mv_n++;
      end
      check("abort no valid", mv_n, 0);
      run_frame(vecs[10], "postreset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
